// File: rtl/tag_fsm.sv
// Gen2-style tag inventory FSM: decodes reader frames, backscatters RN16 / PC+EPC+CRC16.
// Replies start the cycle after the decoding in_eof; each bit holds until out_rdy accepts it.
module tag_fsm #(
    parameter int                     EPC_WORDS   = 6,
    parameter logic [16*EPC_WORDS-1:0] EPC_VALUE  = 96'h3000_1234_5678_9ABC_DEF0_0001,
    parameter int                     ACK_TIMEOUT = 1000,
    parameter logic [15:0]            LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_dat,
    input  logic in_vld,
    input  logic in_sof,
    input  logic in_eof,
    input  logic crc5_ok,
    output logic out_dat,
    output logic out_vld,
    input  logic out_rdy,
    output logic out_sof,
    output logic transmitting
);

    localparam int MSG_W   = 16 + 16*EPC_WORDS;
    localparam int FRAME_W = MSG_W + 16;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [15:0] PC = 16'({EPC_WORDS[4:0], 11'b0});

    function automatic logic [15:0] crc16_of(input logic [MSG_W-1:0] msg);
        logic [15:0] crc;
        crc = 16'hFFFF;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            if (crc[15] ^ msg[i]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
            else                  crc = {crc[14:0], 1'b0};
        end
        return crc;
    endfunction

    // The whole EPC reply is a constant, so the CRC is folded in at elaboration.
    localparam logic [MSG_W-1:0]   MSG       = {PC, EPC_VALUE};
    localparam logic [FRAME_W-1:0] EPC_FRAME = {MSG, ~crc16_of(MSG)};

    typedef enum logic [2:0] {
        S_READY, S_ARBITRATE, S_SND_RN16, S_REPLY, S_SND_EPC, S_ACKNOWLEDGED
    } state_t;

    state_t           state_q, state_d;
    logic             inv_q, inv_d;
    logic [14:0]      slot_q, slot_d;
    logic [15:0]      rn16_q, rn16_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [5:0]       rx_cnt_q, rx_cnt_d;
    logic [31:0]      rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [31:0]      timer_q, timer_d;

    logic        send, eof, is_query, is_qrep, is_ack, is_nak;
    logic        target, new_flag;
    logic [3:0]  q_fld;
    logic [14:0] q_mask, qslot, rep_slot;

    always_comb begin
        send     = (state_q == S_SND_RN16) || (state_q == S_SND_EPC);
        eof      = in_eof && !send;
        // Bits above the received count are always clear after in_sof, so the
        // full-width compares equal the prefix checks on the frame itself.
        is_query = eof && (rx_cnt_q == 6'd22) && (rx_sr_q[31:18] == {10'd0, 4'b1000}) && crc5_ok;
        is_qrep  = eof && (rx_cnt_q == 6'd4)  && (rx_sr_q[31:2] == 30'd0);
        is_ack   = eof && (rx_cnt_q == 6'd18) && (rx_sr_q[31:16] == 16'h0001);
        is_nak   = eof && (rx_cnt_q == 6'd8)  && (rx_sr_q == 32'h0000_00C0);
        target   = rx_sr_q[9];
        q_fld    = rx_sr_q[8:5];
        q_mask   = 15'((16'd1 << q_fld) - 16'd1);
        qslot    = lfsr_q[14:0] & q_mask;
        rep_slot = slot_q - 15'd1;
        new_flag = (state_q == S_ACKNOWLEDGED && target == inv_q) ? ~inv_q : inv_q;

        state_d  = state_q;
        inv_d    = inv_q;
        slot_d   = slot_q;
        rn16_d   = rn16_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        rx_cnt_d = rx_cnt_q;
        rx_sr_d  = rx_sr_q;
        tx_cnt_d = tx_cnt_q;
        timer_d  = timer_q;

        if (!send) begin
            if (in_sof) begin
                rx_cnt_d = 6'd0;
                rx_sr_d  = 32'd0;
            end else if (in_vld) begin
                rx_sr_d  = {rx_sr_q[30:0], in_dat};
                rx_cnt_d = (rx_cnt_q == 6'd32) ? 6'd32 : rx_cnt_q + 6'd1;
            end
        end

        case (state_q)
            S_SND_RN16: begin
                if (out_rdy) begin
                    if (tx_cnt_q == CNT_W'(15)) begin
                        state_d  = S_REPLY;
                        tx_cnt_d = '0;
                        timer_d  = 32'd0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            S_SND_EPC: begin
                if (out_rdy) begin
                    if (tx_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_d  = S_ACKNOWLEDGED;
                        tx_cnt_d = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (state_q == S_REPLY) timer_d = timer_q + 32'd1;
                if (is_query) begin
                    inv_d = new_flag;
                    if (target != new_flag) begin
                        state_d = S_READY;
                    end else begin
                        slot_d = qslot;
                        if (qslot == 15'd0) begin
                            state_d  = S_SND_RN16;
                            rn16_d   = lfsr_q;
                            tx_cnt_d = '0;
                        end else begin
                            state_d = S_ARBITRATE;
                        end
                    end
                end else if (is_qrep) begin
                    if (state_q == S_ARBITRATE) begin
                        slot_d = rep_slot;
                        if (rep_slot == 15'd0) begin
                            state_d  = S_SND_RN16;
                            rn16_d   = lfsr_q;
                            tx_cnt_d = '0;
                        end
                    end else if (state_q == S_REPLY) begin
                        state_d = S_ARBITRATE;
                    end else if (state_q == S_ACKNOWLEDGED) begin
                        inv_d   = ~inv_q;
                        state_d = S_READY;
                    end
                end else if (is_ack && (state_q == S_REPLY || state_q == S_ACKNOWLEDGED)) begin
                    tx_cnt_d = '0;
                    state_d  = (rx_sr_q[15:0] == rn16_q) ? S_SND_EPC : S_ARBITRATE;
                end else if (is_nak && state_q != S_READY) begin
                    state_d = S_ARBITRATE;
                end else if (state_q == S_REPLY && timer_q == 32'(ACK_TIMEOUT - 1)) begin
                    state_d = S_ARBITRATE;
                end
            end
        endcase
    end

    always_comb begin
        out_vld      = send;
        transmitting = send;
        out_sof      = send && (tx_cnt_q == '0);
        out_dat      = 1'b0;
        if (state_q == S_SND_RN16)     out_dat = rn16_q[4'd15 - tx_cnt_q[3:0]];
        else if (state_q == S_SND_EPC) out_dat = EPC_FRAME[CNT_W'(FRAME_W - 1) - tx_cnt_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_READY;
            inv_q    <= 1'b0;
            slot_q   <= 15'd0;
            rn16_q   <= 16'd0;
            lfsr_q   <= LFSR_SEED;
            rx_cnt_q <= 6'd0;
            rx_sr_q  <= 32'd0;
            tx_cnt_q <= '0;
            timer_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            inv_q    <= inv_d;
            slot_q   <= slot_d;
            rn16_q   <= rn16_d;
            lfsr_q   <= lfsr_d;
            rx_cnt_q <= rx_cnt_d;
            rx_sr_q  <= rx_sr_d;
            tx_cnt_q <= tx_cnt_d;
            timer_q  <= timer_d;
        end
    end

endmodule
